// File: rtl/wm_pkg.sv
// rtl/wm_pkg.sv - shared types and constants for the watermark insertion sequencer
package wm_pkg;

  // One state per memory access slot, plus datapath wait, write and end-of-frame
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_RD_P  = 4'd1,
    ST_RD_L  = 4'd2,
    ST_RD_U  = 4'd3,
    ST_RD_UL = 4'd4,
    ST_CAP   = 4'd5,
    ST_HOLD  = 4'd6,
    ST_WR    = 4'd7,
    ST_DONE  = 4'd8
  } wm_state_e;

  localparam int INS_LAT_DEF = 1;

  // Symbol handed to the datapath for border pixels (no watermark carried)
  localparam logic [1:0] WM_NONE = 2'b00;

endpackage

// File: rtl/wm_addr_gen.sv
// rtl/wm_addr_gen.sv - raster counters, neighbour addresses and border/last flags
module wm_addr_gen #(
  parameter int IMG_W     = 64,
  parameter int IMG_H     = 64,
  parameter int ADDR_W    = 12,
  parameter int WM_ADDR_W = 12
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_advance,
  output logic [ADDR_W-1:0]    o_pix,
  output logic [ADDR_W-1:0]    o_pix_l,
  output logic [ADDR_W-1:0]    o_pix_u,
  output logic [ADDR_W-1:0]    o_pix_ul,
  output logic [WM_ADDR_W-1:0] o_wm_idx,
  output logic                 o_border,
  output logic                 o_last
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  logic [COL_W-1:0]     r_col;
  logic [ROW_W-1:0]     r_row;
  logic [ADDR_W-1:0]    r_pix;
  logic [WM_ADDR_W-1:0] r_wm_idx;

  // Step one pixel in raster order; the frame's last pixel returns everything to the origin
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col    <= '0;
      r_row    <= '0;
      r_pix    <= '0;
      r_wm_idx <= '0;
    end else if (i_advance) begin
      if (o_last) begin
        r_col    <= '0;
        r_row    <= '0;
        r_pix    <= '0;
        r_wm_idx <= '0;
      end else begin
        if (r_col == COL_W'(IMG_W - 1)) begin
          r_col <= '0;
          r_row <= r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
        r_pix <= r_pix + ADDR_W'(1);
        // Only interior pixels consume a watermark symbol
        if (!o_border) begin
          r_wm_idx <= r_wm_idx + WM_ADDR_W'(1);
        end
      end
    end
  end

  // Neighbour addresses are only used for interior pixels, so they never underflow
  assign o_pix    = r_pix;
  assign o_pix_l  = r_pix - ADDR_W'(1);
  assign o_pix_u  = r_pix - ADDR_W'(IMG_W);
  assign o_pix_ul = r_pix - ADDR_W'(IMG_W + 1);
  assign o_wm_idx = r_wm_idx;
  assign o_border = (r_row == '0) || (r_col == '0);
  assign o_last   = (r_row == ROW_W'(IMG_H - 1)) && (r_col == COL_W'(IMG_W - 1));

endmodule

// File: rtl/wm_insert_ctrl.sv
// rtl/wm_insert_ctrl.sv - frame sequencer feeding the watermark insertion datapath
module wm_insert_ctrl
  import wm_pkg::*;
#(
  parameter int IMG_W     = 64,
  parameter int IMG_H     = 64,
  parameter int ADDR_W    = 12,
  parameter int WM_ADDR_W = 12,
  parameter int INS_LAT   = INS_LAT_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_img_rd_en,
  output logic [ADDR_W-1:0]    o_img_addr,
  input  logic [7:0]           i_img_rd_data,
  output logic                 o_wm_rd_en,
  output logic [WM_ADDR_W-1:0] o_wm_addr,
  input  logic [1:0]           i_wm_rd_data,
  output logic [7:0]           o_ins_data1,
  output logic [7:0]           o_ins_data2,
  output logic [7:0]           o_ins_data3,
  output logic [7:0]           o_ins_data4,
  output logic [1:0]           o_ins_wm,
  input  logic [7:0]           i_ins_result,
  output logic                 o_out_we,
  output logic [ADDR_W-1:0]    o_out_addr,
  output logic [7:0]           o_out_data,
  input  logic                 i_out_ready
);

  localparam int LAT_W = $clog2(INS_LAT) + 1;

  wm_state_e r_state;
  wm_state_e w_next_state;

  logic [LAT_W-1:0]     r_lat_cnt;
  logic [7:0]           r_ins_data1;
  logic [7:0]           r_ins_data2;
  logic [7:0]           r_ins_data3;
  logic [7:0]           r_ins_data4;
  logic [1:0]           r_ins_wm;

  logic [ADDR_W-1:0]    w_pix;
  logic [ADDR_W-1:0]    w_pix_l;
  logic [ADDR_W-1:0]    w_pix_u;
  logic [ADDR_W-1:0]    w_pix_ul;
  logic [WM_ADDR_W-1:0] w_wm_idx;
  logic                 w_border;
  logic                 w_last;
  logic                 w_advance;

  // A pixel is finished once the output memory takes its write
  assign w_advance = (r_state == ST_WR) && i_out_ready;

  wm_addr_gen #(
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .ADDR_W    (ADDR_W),
    .WM_ADDR_W (WM_ADDR_W)
  ) u_addr_gen (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_advance (w_advance),
    .o_pix     (w_pix),
    .o_pix_l   (w_pix_l),
    .o_pix_u   (w_pix_u),
    .o_pix_ul  (w_pix_ul),
    .o_wm_idx  (w_wm_idx),
    .o_border  (w_border),
    .o_last    (w_last)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Datapath latency counter; restarts every time HOLD is entered
  always_ff @(posedge i_clk) begin
    if (i_rst || (r_state != ST_HOLD)) begin
      r_lat_cnt <= '0;
    end else begin
      r_lat_cnt <= r_lat_cnt + LAT_W'(1);
    end
  end

  // Capture each read one cycle after it was issued; registers hold elsewhere
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ins_data1 <= '0;
      r_ins_data2 <= '0;
      r_ins_data3 <= '0;
      r_ins_data4 <= '0;
      r_ins_wm    <= '0;
    end else begin
      case (r_state)
        ST_RD_L: begin
          r_ins_data1 <= i_img_rd_data;
          r_ins_wm    <= i_wm_rd_data;
        end
        ST_RD_U:  r_ins_data2 <= i_img_rd_data;
        ST_RD_UL: r_ins_data3 <= i_img_rd_data;
        ST_CAP: begin
          if (w_border) begin
            r_ins_data1 <= i_img_rd_data;
            r_ins_wm    <= WM_NONE;
          end else begin
            r_ins_data4 <= i_img_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ins_data1 = r_ins_data1;
  assign o_ins_data2 = r_ins_data2;
  assign o_ins_data3 = r_ins_data3;
  assign o_ins_data4 = r_ins_data4;
  assign o_ins_wm    = r_ins_wm;

  // Next-state decode and per-state memory strobes
  always_comb begin
    w_next_state = r_state;
    o_busy       = (r_state != ST_IDLE);
    o_done       = 1'b0;
    o_img_rd_en  = 1'b0;
    o_img_addr   = '0;
    o_wm_rd_en   = 1'b0;
    o_wm_addr    = '0;
    o_out_we     = 1'b0;
    o_out_addr   = '0;
    o_out_data   = '0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_next_state = ST_RD_P;
        end
      end
      ST_RD_P: begin
        o_img_rd_en = 1'b1;
        o_img_addr  = w_pix;
        if (!w_border) begin
          o_wm_rd_en = 1'b1;
          o_wm_addr  = w_wm_idx;
        end
        w_next_state = w_border ? ST_CAP : ST_RD_L;
      end
      ST_RD_L: begin
        o_img_rd_en  = 1'b1;
        o_img_addr   = w_pix_l;
        w_next_state = ST_RD_U;
      end
      ST_RD_U: begin
        o_img_rd_en  = 1'b1;
        o_img_addr   = w_pix_u;
        w_next_state = ST_RD_UL;
      end
      ST_RD_UL: begin
        o_img_rd_en  = 1'b1;
        o_img_addr   = w_pix_ul;
        w_next_state = ST_CAP;
      end
      ST_CAP: begin
        w_next_state = w_border ? ST_WR : ST_HOLD;
      end
      ST_HOLD: begin
        if (r_lat_cnt == LAT_W'(INS_LAT - 1)) begin
          w_next_state = ST_WR;
        end
      end
      ST_WR: begin
        o_out_we   = 1'b1;
        o_out_addr = w_pix;
        // Border pixels bypass the datapath and are copied through unchanged
        o_out_data = w_border ? r_ins_data1 : i_ins_result;
        if (i_out_ready) begin
          w_next_state = w_last ? ST_DONE : ST_RD_P;
        end
      end
      ST_DONE: begin
        o_done       = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wm_insert_ctrl.sv
// tb/tb_wm_insert_ctrl.sv - directed self-checking bench for wm_insert_ctrl
module tb_wm_insert_ctrl;

  localparam int W   = 4;
  localparam int H   = 4;
  localparam int AW  = 12;
  localparam int WAW = 12;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           busy, done;
  logic           img_rd_en, wm_rd_en;
  logic [AW-1:0]  img_addr;
  logic [WAW-1:0] wm_addr;
  logic [7:0]     img_rd_data = 8'd0;
  logic [1:0]     wm_rd_data = 2'd0;
  logic [7:0]     ins_data1, ins_data2, ins_data3, ins_data4;
  logic [1:0]     ins_wm;
  logic [7:0]     ins_result = 8'd0;
  logic           out_we;
  logic [AW-1:0]  out_addr;
  logic [7:0]     out_data;
  logic           out_ready = 1'b1;

  logic [7:0] img_mem [16];
  logic [1:0] wm_mem  [16];

  int n_tests = 0;
  int n_fail  = 0;

  int busy_cnt = 0, done_cnt = 0, stall_left = 0, stall_hold = 0;
  logic [7:0]    stall_exp = 8'd0;
  logic [AW-1:0] wr_addr_q[$];
  logic [7:0]    wr_data_q[$];
  logic [WAW-1:0] wm_q[$];
  bit            cap_seen = 1'b0;
  logic [7:0]    cap_d1, cap_d2, cap_d3, cap_d4;
  logic [1:0]    cap_wm;
  bit            fin;

  always #5 clk = ~clk;

  wm_insert_ctrl #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .WM_ADDR_W(WAW), .INS_LAT(1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_busy(busy), .o_done(done),
    .o_img_rd_en(img_rd_en), .o_img_addr(img_addr), .i_img_rd_data(img_rd_data),
    .o_wm_rd_en(wm_rd_en), .o_wm_addr(wm_addr), .i_wm_rd_data(wm_rd_data),
    .o_ins_data1(ins_data1), .o_ins_data2(ins_data2),
    .o_ins_data3(ins_data3), .o_ins_data4(ins_data4),
    .o_ins_wm(ins_wm), .i_ins_result(ins_result),
    .o_out_we(out_we), .o_out_addr(out_addr), .o_out_data(out_data),
    .i_out_ready(out_ready)
  );

  // 1-cycle RAMs and a 1-cycle datapath that adds the symbol to the pixel
  always @(posedge clk) begin
    if (img_rd_en) img_rd_data <= img_mem[img_addr[3:0]];
    if (wm_rd_en)  wm_rd_data  <= wm_mem[wm_addr[3:0]];
    ins_result <= ins_data1 + {6'd0, ins_wm};
  end

  // Monitor plus out_ready stall driver, away from the active edge
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (wm_rd_en) wm_q.push_back(wm_addr);
    if (out_we && out_addr == 12'd5 && !cap_seen) begin
      cap_seen = 1'b1;
      cap_d1 = ins_data1; cap_d2 = ins_data2; cap_d3 = ins_data3; cap_d4 = ins_data4;
      cap_wm = ins_wm;
    end
    if (stall_left > 0 && out_we && out_addr == 12'd5) begin
      out_ready = 1'b0;
      stall_left--;
      if (out_data == stall_exp) stall_hold++;
    end else begin
      out_ready = 1'b1;
    end
    if (out_we && out_ready) begin
      wr_addr_q.push_back(out_addr);
      wr_data_q.push_back(out_data);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference pixel: border copied, interior gets its raster-ordered symbol added
  function automatic logic [7:0] exp_pix(input int i);
    int r, c;
    r = i / W;
    c = i % W;
    if (r == 0 || c == 0) return img_mem[i];
    return img_mem[i] + {6'd0, wm_mem[(r - 1) * (W - 1) + (c - 1)]};
  endfunction

  task automatic clear_mon();
    wr_addr_q.delete(); wr_data_q.delete(); wm_q.delete();
    busy_cnt = 0; done_cnt = 0; stall_hold = 0; cap_seen = 1'b0;
  endtask

  task automatic run_frame(input int stall_n, input int restart_at, output bit finished);
    clear_mon();
    stall_left = stall_n;
    stall_exp  = exp_pix(5);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    finished = 1'b0;
    for (int cyc = 1; cyc < 400 && !finished; cyc++) begin
      @(negedge clk);
      start = (cyc == restart_at);
      if (done_cnt > 0) finished = 1'b1;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int exp_busy);
    check_eq({tag, "_nwr"}, wr_addr_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < wr_addr_q.size()) begin
        check_eq($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], i);
        check_eq($sformatf("%s_data%0d", tag, i), wr_data_q[i], exp_pix(i));
      end
    end
    check_eq({tag, "_busy"}, busy_cnt, exp_busy);
    check_eq({tag, "_done"}, done_cnt, 1);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_rd_en"}, {img_rd_en, wm_rd_en, out_we}, 0);
    check_eq({tag, "_img_addr"}, img_addr, 0);
    check_eq({tag, "_wm_addr"}, wm_addr, 0);
    check_eq({tag, "_out_addr"}, out_addr, 0);
    check_eq({tag, "_out_data"}, out_data, 0);
    check_eq({tag, "_ins"}, {ins_data1, ins_data2, ins_data3, ins_data4, ins_wm}, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      img_mem[i] = 8'd100;
      wm_mem[i]  = 2'd0;
    end
    repeat (2) @(negedge clk);
    check_idle("rst");
    rst = 1'b0;

    // Flat image, zero watermark
    run_frame(0, -1, fin);
    check_eq("f1_finish", fin, 1);
    check_frame("f1", 85);

    // Ramp image, cycling symbols, stray start mid-frame
    for (int i = 0; i < 16; i++) begin
      img_mem[i] = 8'(i * 10);
      wm_mem[i]  = 2'((i + 1) % 4);
    end
    run_frame(0, 20, fin);
    check_eq("f2_finish", fin, 1);
    check_frame("f2", 85);
    check_eq("f2_cap_seen", cap_seen, 1);
    check_eq("f2_d1", cap_d1, 50);
    check_eq("f2_d2", cap_d2, 40);
    check_eq("f2_d3", cap_d3, 10);
    check_eq("f2_d4", cap_d4, 0);
    check_eq("f2_wm", cap_wm, 1);
    check_eq("f2_nwm", wm_q.size(), 9);
    for (int k = 0; k < 9; k++) begin
      if (k < wm_q.size()) check_eq($sformatf("f2_wm_addr%0d", k), wm_q[k], k);
    end

    // Output stall at the first interior write
    run_frame(5, -1, fin);
    check_eq("f3_finish", fin, 1);
    check_frame("f3", 90);
    check_eq("f3_hold", stall_hold, 5);

    // Reset in the middle of a frame, then a clean frame
    clear_mon();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (29) @(negedge clk);
    check_eq("f4_busy_mid", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_idle("f4_rst");
    rst = 1'b0;
    run_frame(0, -1, fin);
    check_eq("f5_finish", fin, 1);
    check_frame("f5", 85);
    check_eq("f5_nwm", wm_q.size(), 9);
    if (wm_q.size() > 0) check_eq("f5_wm_first", wm_q[0], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
